// File: rtl/lut4_rv32_v1.sv
// Purpose: RV32 4-bit-index lookup: eight rs1 nibbles each select a 2-bit entry from the rs2 table.
// Latency: rd is combinational (0 cycles); rd_q/valid_o are a one-cycle registered copy.
// Backpressure: none; rd_q captures unconditionally whenever valid_i is high.
module lut4_rv32_v1 (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] rd,
    input  logic        valid_i,
    output logic [31:0] rd_q,
    output logic        valid_o
);

    logic [1:0]  lut [16];
    logic [31:0] rd_c;
    logic [31:0] cap_d;
    logic [31:0] cap_q;
    logic        valid_d;
    logic        valid_q;

    // Unpack the 16-entry table of 2-bit values from rs2; entry 0 sits in the low bits.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            lut[i] = rs2[2*i +: 2];
        end
    end

    // Eight independent lookups sharing one table; upper two bits of each nibble stay zero.
    always_comb begin
        rd_c = '0;
        for (int k = 0; k < 8; k++) begin
            rd_c[4*k +: 2] = lut[rs1[4*k +: 4]];
        end
    end

    assign rd = rd_c;

    // Capture the lookup result only when qualified; otherwise hold the last captured value.
    always_comb begin
        cap_d   = cap_q;
        valid_d = valid_i;
        if (valid_i) begin
            cap_d = rd_c;
        end
    end

    // Registered copy; reset clears both the data and the valid flag immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cap_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            cap_q   <= cap_d;
            valid_q <= valid_d;
        end
    end

    assign rd_q    = cap_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_lut4_rv32_v1.sv
module tb_lut4_rv32_v1;

    logic        clk;
    logic        resetn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rd;
    logic        valid_i;
    logic [31:0] rd_q;
    logic        valid_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] comb_sb [$];
    logic [32:0] reg_sb  [$];
    logic [31:0] exp_rdq;

    lut4_rv32_v1 dut (
        .clk     (clk),
        .resetn  (resetn),
        .rs1     (rs1),
        .rs2     (rs2),
        .rd      (rd),
        .valid_i (valid_i),
        .rd_q    (rd_q),
        .valid_o (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden model: shift-and-mask nibble lookup.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [31:0] idx;
        r = 32'h0;
        for (int k = 0; k < 8; k++) begin
            idx = (a >> (4 * k)) & 32'hF;
            r   = r | (((b >> (2 * idx)) & 32'h3) << (4 * k));
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a vector, push expected rd, then pop and compare after settling.
    task automatic comb_step(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp);
        logic [31:0] e;
        rs1 = a;
        rs2 = b;
        comb_sb.push_back(exp);
        #1;
        e = comb_sb.pop_front();
        chk(tag, rd, e);
        chk({tag, "_mask"}, rd & 32'hCCCCCCCC, 32'h0);
    endtask

    // Pop the expected registered state and compare against rd_q/valid_o.
    task automatic reg_check(input string tag);
        logic [32:0] e;
        e = reg_sb.pop_front();
        chk({tag, "_rdq"}, rd_q, e[31:0]);
        chk({tag, "_vld"}, {31'h0, valid_o}, {31'h0, e[32]});
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        v;

        resetn  = 1'b0;
        valid_i = 1'b1;
        rs1     = 32'h0;
        rs2     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reg_sb.push_back({1'b0, 32'h0});
        reg_check("reset");

        // Combinational lookups work while reset is asserted.
        @(negedge clk);
        comb_step("iota",      32'h76543210, 32'hE4E4E4E4, 32'h32103210);
        comb_step("all_ones",  32'h89ABCDEF, 32'hFFFFFFFF, 32'h33333333);
        comb_step("zero_tbl",  32'h89ABCDEF, 32'h00000000, 32'h00000000);
        comb_step("lut0_only", 32'h0F0F0F0F, 32'h00000003, 32'h30303030);
        comb_step("lut15_hi",  32'hFFFFFFFF, 32'hC0000000, 32'h33333333);
        comb_step("lut15_lo",  32'h00000000, 32'hC0000000, 32'h00000000);
        comb_step("repeat",    32'h55555555, 32'h00000C00, 32'h33333333);
        reg_sb.push_back({1'b0, 32'h0});
        reg_check("reset_hold");

        // Release reset; first edge captures the iota vector.
        @(negedge clk);
        resetn  = 1'b1;
        valid_i = 1'b1;
        comb_step("cap_vec", 32'h76543210, 32'hE4E4E4E4, 32'h32103210);
        reg_sb.push_back({1'b1, 32'h32103210});
        @(posedge clk);
        #1;
        reg_check("first_cap");

        // valid_i low: rd_q holds, valid_o drops.
        @(negedge clk);
        valid_i = 1'b0;
        comb_step("hold_vec", 32'h89ABCDEF, 32'hFFFFFFFF, 32'h33333333);
        reg_sb.push_back({1'b0, 32'h32103210});
        @(posedge clk);
        #1;
        reg_check("hold");

        // Random vectors every cycle, checking both paths.
        exp_rdq = 32'h32103210;
        for (int n = 0; n < 120; n++) begin
            @(negedge clk);
            a = $urandom;
            b = $urandom;
            v = 1'($urandom_range(0, 1));
            valid_i = v;
            comb_step("rand", a, b, model(a, b));
            if (v) exp_rdq = model(a, b);
            reg_sb.push_back({v, exp_rdq});
            @(posedge clk);
            #1;
            reg_check("rand_reg");
        end

        // Asynchronous reset between edges clears the registered path at once.
        @(negedge clk);
        valid_i = 1'b1;
        comb_step("pre_arst", 32'hFEDCBA98, 32'hE4E4E4E4, 32'h32103210);
        reg_sb.push_back({1'b1, 32'h32103210});
        @(posedge clk);
        #1;
        reg_check("pre_arst");
        #2;
        resetn = 1'b0;
        #1;
        reg_sb.push_back({1'b0, 32'h0});
        reg_check("mid_arst");

        // Release and resume capture on the first edge.
        @(negedge clk);
        resetn = 1'b1;
        comb_step("post_arst", 32'h0F0F0F0F, 32'h00000003, 32'h30303030);
        reg_sb.push_back({1'b1, 32'h30303030});
        @(posedge clk);
        #1;
        reg_check("post_arst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
